// File: rtl/pulse_avg_readout.sv
// pulse_avg_readout: reads averaged I/Q accumulators, scales by 2^-shift with sc16 saturation and emits CVITA packets; define PULSE_AVG_ROUND_EN for round-half-up scaling
module pulse_avg_readout #(
    parameter int MAX_PULSE_SIZE = 8192,
    parameter int ADDR_WIDTH = 13,
    parameter int ACC_WIDTH = 24,
    parameter int SPP = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start,
    input  logic [31:0]            pulse_size,
    input  logic [4:0]             shift,
    input  logic [31:0]            sid,
    input  logic                   has_time,
    input  logic [63:0]            vita_time,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_ena,
    input  logic [2*ACC_WIDTH-1:0] rd_data,
    output logic [31:0]            o_tdata,
    output logic [127:0]           o_tuser,
    output logic                   o_tvalid,
    output logic                   o_tlast,
    input  logic                   o_tready
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(32767);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -(ACC_WIDTH+1)'(32768);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   n_q, rd_cnt_q, pkt_start_q, pkt_pos_q;
    logic [4:0]      shift_q;
    logic [31:0]     sid_q, s0_q, s1_q;
    logic            has_time_q, busy_q, done_q, rd_vld_q;
    logic [63:0]     time_q;
    logic [11:0]     seq_q;
    logic [1:0]      occ_q, slot;
    logic [2:0]      credit;
    logic [CW-1:0]   n_in, remain, pkt_len;
    logic            pop, eob, last, fin;
    logic [31:0]     din;

    // Arithmetic shift with optional round-half-up, then clamp to signed 16 bits.
    function automatic logic [15:0] scale(input logic [ACC_WIDTH-1:0] acc, input logic [4:0] sh);
        logic signed [ACC_WIDTH:0] x;
        x = $signed({acc[ACC_WIDTH-1], acc});
`ifdef PULSE_AVG_ROUND_EN
        if (sh != 5'd0 && 32'(sh) <= ACC_WIDTH) x = x + ((ACC_WIDTH+1)'(1) << (sh - 5'd1));
`endif
        x = x >>> sh;
        return x > SAT_MAX ? 16'h7fff : x < SAT_MIN ? 16'h8000 : x[15:0];
    endfunction

    assign n_in    = pulse_size > 32'(MAX_PULSE_SIZE) ? CW'(MAX_PULSE_SIZE) : pulse_size[CW-1:0];
    assign pop     = (occ_q != 2'd0) && o_tready;
    assign remain  = n_q - pkt_start_q;
    assign pkt_len = remain > CW'(SPP) ? CW'(SPP) : remain;
    assign eob     = remain <= CW'(SPP);
    assign last    = pkt_pos_q == pkt_len - CW'(1);
    assign fin     = pop && last && eob;
    assign slot    = occ_q - {1'b0, pop};
    assign din     = {scale(rd_data[2*ACC_WIDTH-1:ACC_WIDTH], shift_q), scale(rd_data[ACC_WIDTH-1:0], shift_q)};
    // Credit counts skid entries plus data on the read bus, net of the beat leaving this cycle,
    // so a 2-entry skid sustains one sample per cycle.
    assign credit  = {1'b0, occ_q} + {2'b0, rd_vld_q};
    assign rd_ena  = state_q == STREAM && rd_cnt_q < n_q && credit < 3'd2 + {2'b0, pop};
    assign rd_addr = rd_ena ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;
    assign o_tvalid = occ_q != 2'd0;
    assign o_tdata  = o_tvalid ? s0_q : '0;
    assign o_tlast  = o_tvalid && last;
    assign o_tuser  = o_tvalid ? {2'b00, has_time_q, eob, seq_q, 16'({pkt_len, 2'b00}) + (has_time_q ? 16'd16 : 16'd8),
                                  sid_q, time_q + 64'(pkt_start_q)} : '0;
    assign busy = busy_q;
    assign done = done_q;

    // Skid buffer: returning samples land in the first slot left free after this cycle's pop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            occ_q    <= '0;
            rd_vld_q <= 1'b0;
            s0_q     <= '0;
            s1_q     <= '0;
        end else begin
            rd_vld_q <= rd_ena;
            occ_q    <= occ_q + {1'b0, rd_vld_q} - {1'b0, pop};
            if (pop && occ_q == 2'd2) s0_q <= s1_q;
            if (rd_vld_q && slot == 2'd0) s0_q <= din;
            if (rd_vld_q && slot == 2'd1) s1_q <= din;
        end
    end

    // Control FSM with read counter, packet position tracking and the persistent sequence number.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            n_q         <= '0;
            rd_cnt_q    <= '0;
            pkt_start_q <= '0;
            pkt_pos_q   <= '0;
            shift_q     <= '0;
            sid_q       <= '0;
            has_time_q  <= 1'b0;
            time_q      <= '0;
            seq_q       <= '0;
        end else begin
            if (rd_ena) rd_cnt_q <= rd_cnt_q + CW'(1);
            if (pop) begin
                pkt_pos_q <= last ? '0 : pkt_pos_q + CW'(1);
                if (last) begin
                    pkt_start_q <= pkt_start_q + pkt_len;
                    seq_q       <= seq_q + 12'd1;
                end
            end
            case (state_q)
                IDLE: if (start) begin
                    n_q         <= n_in;
                    shift_q     <= shift;
                    sid_q       <= sid;
                    has_time_q  <= has_time;
                    time_q      <= vita_time;
                    rd_cnt_q    <= '0;
                    pkt_start_q <= '0;
                    pkt_pos_q   <= '0;
                    busy_q      <= n_in != '0;
                    state_q     <= n_in != '0 ? STREAM : DONE;
                end
                STREAM: if (fin) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    done_q  <= !done_q;
                    state_q <= done_q ? IDLE : DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_avg_readout.sv
// tb_pulse_avg_readout: scoreboard bench for pulse_avg_readout with a behavioural pulse memory
module tb_pulse_avg_readout;
    logic         clk = 1'b0, reset, clear, start, has_time, busy, done, rd_ena;
    logic         o_tvalid, o_tlast, o_tready;
    logic [31:0]  pulse_size, sid, o_tdata;
    logic [4:0]   shift;
    logic [63:0]  vita_time;
    logic [12:0]  rd_addr;
    logic [47:0]  rd_data;
    logic [127:0] o_tuser;

    pulse_avg_readout dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .pulse_size(pulse_size),
        .shift(shift), .sid(sid), .has_time(has_time), .vita_time(vita_time), .busy(busy),
        .done(done), .rd_addr(rd_addr), .rd_ena(rd_ena), .rd_data(rd_data), .o_tdata(o_tdata),
        .o_tuser(o_tuser), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] d; logic [127:0] u; logic l;} beat_t;

    beat_t        exp_q[$];
    logic [127:0] hdr_q[$];
    logic [47:0]  mem [8192];
    logic [31:0]  exp_data [8192];
    int           n_chk = 0, n_pass = 0, cyc = 0, acc_cnt = 0, iss_cnt = 0, viol = 0, done_cnt = 0, last_hs_cyc = 0;
    logic [11:0]  exp_seq = 12'd0;
    logic         bp = 1'b0, stall_q = 1'b0, first = 1'b1;
    beat_t        cur, prev;

`ifdef PULSE_AVG_ROUND_EN
    localparam logic [15:0] P56 = 16'd4, N55 = 16'hfffd, N56 = 16'hfffd;
`else
    localparam logic [15:0] P56 = 16'd3, N55 = 16'hfffc, N56 = 16'hfffc;
`endif

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= rd_ena ? mem[rd_addr] : 48'd0;

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 o_tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and read credit.
    always @(negedge clk) begin
        cur = {o_tdata, o_tuser, o_tlast};
        if (stall_q) chk("hold stable", {o_tvalid, cur}, {1'b1, prev});
        if (rd_ena) begin
            if (iss_cnt - acc_cnt - int'(o_tvalid && o_tready) + 1 > 2) viol++;
            iss_cnt++;
        end
        if (o_tvalid && o_tready) begin
            if (first) hdr_q.push_back(o_tuser);
            first = o_tlast;
            if (exp_q.size() == 0) chk("spurious beat, queue size", exp_q.size(), 1);
            else chk("beat", cur, exp_q.pop_front());
            acc_cnt++;
            last_hs_cyc = cyc;
        end
        if (done) done_cnt++;
        if (clear) begin
            first = 1'b1;
            iss_cnt = acc_cnt;
        end
        stall_q = o_tvalid && !o_tready;
        prev = cur;
    end

    function automatic logic [127:0] hdr(int ps, int ns, bit eob, logic [11:0] sq, bit ht, logic [63:0] vt, logic [31:0] sd);
        return {2'b00, ht, eob, sq, 16'(4 * ns + 8 + (ht ? 8 : 0)), sd, vt + 64'(ps)};
    endfunction

    task automatic expect_pulse(input int n, input bit ht, input logic [63:0] vt, input logic [31:0] sd);
        for (int p = 0; p < n; p += 256) begin
            int ns;
            ns = (n - p > 256) ? 256 : n - p;
            for (int k = 0; k < ns; k++)
                exp_q.push_back({exp_data[p + k], hdr(p, ns, p + ns == n, exp_seq, ht, vt, sd), k == ns - 1});
            exp_seq = exp_seq + 12'd1;
        end
    endtask

    task automatic fill(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            mem[i] = ramp ? {24'(i), 24'(-i)} : {24'(4 * i + 1), 24'(-4 * i)};
            exp_data[i] = {16'(i), 16'(-i)};
        end
    endtask

    task automatic start_pulse(input int n, input int sh, input bit ht, input logic [63:0] vt,
                               input logic [31:0] sd, output int sc);
        @(posedge clk);
        #1;
        pulse_size = n; shift = 5'(sh); has_time = ht; vita_time = vt; sid = sd; start = 1'b1;
        @(negedge clk);
        sc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int dc);
        dc = -1;
        for (int t = 0; t < 20000 && dc < 0; t++) begin
            @(negedge clk);
            if (done) dc = cyc;
        end
        if (dc < 0) chk({nm, " done seen"}, done, 1);
    endtask

    task automatic finish_pulse(input string nm);
        int dc;
        wait_done(nm, dc);
        chk({nm, " done one cycle after last beat"}, dc, last_hs_cyc + 1);
        chk({nm, " queue drained"}, exp_q.size(), 0);
    endtask

    task automatic run_pulse(input string nm, input int n, input int sh, input bit ht,
                             input logic [63:0] vt, input logic [31:0] sd);
        int sc;
        expect_pulse(n, ht, vt, sd);
        start_pulse(n, sh, ht, vt, sd, sc);
        finish_pulse(nm);
    endtask

    initial begin
        int sc, dc, a0, d0;
        int len_e [3] = '{1032, 1032, 360};
        reset = 1'b1; clear = 1'b0; start = 1'b0; pulse_size = 0; shift = 0;
        sid = 0; has_time = 1'b0; vita_time = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_ena", rd_ena, 0);
        chk("reset tvalid", o_tvalid, 0);
        chk("reset tlast", o_tlast, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset tdata", o_tdata, 0);
        chk("reset tuser", o_tuser, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic read-out with latency checks and an ignored start while busy
        fill(600, 1'b1);
        hdr_q.delete();
        expect_pulse(600, 1'b0, 64'd0, 32'hA5A5_0001);
        start_pulse(600, 0, 1'b0, 64'd0, 32'hA5A5_0001, sc);
        @(negedge clk);
        chk("busy at start+1", busy, 1);
        chk("rd_ena at start+1", rd_ena, 1);
        chk("rd_addr at start+1", rd_addr, 0);
        @(negedge clk);
        chk("tvalid low at start+2", o_tvalid, 0);
        @(negedge clk);
        chk("tvalid at start+3", o_tvalid, 1);
        repeat (40) @(posedge clk);
        #1 pulse_size = 3; shift = 7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_pulse("basic");
        chk("basic packet count", hdr_q.size(), 3);
        if (hdr_q.size() >= 3)
            for (int j = 0; j < 3; j++) begin
                chk("basic length", hdr_q[j][111:96], len_e[j]);
                chk("basic eob", hdr_q[j][124], j == 2);
                chk("basic seqnum", hdr_q[j][123:112], j);
            end

        // Scaling and saturation, hand-computed
        mem[0] = {24'h000037, 24'h000038}; exp_data[0] = {16'd3, P56};
        mem[1] = {24'hffffc9, 24'hffffc8}; exp_data[1] = {N55, N56};
        mem[2] = {24'h7fffff, 24'h800000}; exp_data[2] = {16'h7fff, 16'h8000};
        mem[3] = {24'h000100, 24'h000010}; exp_data[3] = {16'h0010, 16'h0001};
        run_pulse("scale shift4", 4, 4, 1'b0, 64'd0, 32'h0001_0002);
        mem[0] = {24'h7fffff, 24'h800000}; exp_data[0] = {16'h7fff, 16'h8000};
        mem[1] = {24'h00ffff, 24'hff0000}; exp_data[1] = {16'h7fff, 16'h8000};
        mem[2] = {24'h000123, 24'hfffedc}; exp_data[2] = {16'h0123, 16'hfedc};
        run_pulse("scale shift0", 3, 0, 1'b0, 64'd0, 32'h0001_0002);
        mem[0] = {24'h800000, 24'h7fffff}; exp_data[0] = {16'hffff, 16'h0000};
        run_pulse("scale shift30", 1, 30, 1'b0, 64'd0, 32'h0001_0002);

        // Timestamps
        fill(512, 1'b1);
        hdr_q.delete();
        run_pulse("timestamp", 512, 0, 1'b1, 64'd1000, 32'h1234_5678);
        chk("ts packet count", hdr_q.size(), 2);
        if (hdr_q.size() >= 2) begin
            chk("ts time pkt0", hdr_q[0][63:0], 1000);
            chk("ts time pkt1", hdr_q[1][63:0], 1256);
            chk("ts length pkt0", hdr_q[0][111:96], 1040);
            chk("ts length pkt1", hdr_q[1][111:96], 1040);
            chk("ts has_time bit", hdr_q[1][125], 1);
        end

        // Backpressure at 30% ready
        fill(1000, 1'b0);
        viol = 0;
        bp = 1'b1;
        run_pulse("backpressure", 1000, 2, 1'b0, 64'd77, 32'hCAFE_0003);
        bp = 1'b0;
        chk("read credit violations", viol, 0);

        // Empty pulse
        a0 = acc_cnt;
        start_pulse(0, 0, 1'b0, 64'd0, 32'd0, sc);
        wait_done("empty", dc);
        chk("empty done at start+2", dc, sc + 2);
        chk("empty no beats", acc_cnt, a0);

        // Sequence number wrap
        mem[0] = 48'h000005_fffffb; exp_data[0] = {16'd5, 16'hfffb};
        while (exp_seq != 12'd4095) run_pulse("seq fill", 1, 0, 1'b0, 64'd0, 32'd9);
        hdr_q.delete();
        run_pulse("seq 4095", 1, 0, 1'b0, 64'd0, 32'd9);
        run_pulse("seq wrap", 1, 0, 1'b0, 64'd0, 32'd9);
        chk("wrap packet count", hdr_q.size(), 2);
        if (hdr_q.size() >= 2) begin
            chk("seqnum 4095", hdr_q[0][123:112], 4095);
            chk("seqnum wraps to 0", hdr_q[1][123:112], 0);
        end

        // Abort mid-packet
        fill(600, 1'b0);
        expect_pulse(600, 1'b0, 64'd0, 32'd11);
        start_pulse(600, 2, 1'b0, 64'd0, 32'd11, sc);
        a0 = acc_cnt;
        for (int t = 0; t < 2000 && acc_cnt - a0 < 100; t++) @(negedge clk);
        chk("abort reached mid-packet", acc_cnt - a0 >= 100, 1);
        @(posedge clk);
        #1 clear = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clear tvalid", o_tvalid, 0);
        chk("clear tdata", o_tdata, 0);
        chk("clear tuser", o_tuser, 0);
        chk("clear busy", busy, 0);
        chk("clear rd_ena", rd_ena, 0);
        exp_q.delete();
        exp_seq = 12'd0;
        hdr_q.delete();
        repeat (10) @(negedge clk);
        chk("no done after clear", done_cnt, d0);
        run_pulse("post-abort", 10, 2, 1'b0, 64'd0, 32'd12);
        chk("post-abort seqnum", hdr_q.size() > 0 ? hdr_q[0][123:112] : 12'hfff, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
